// File: rtl/gcd_operand_feeder_if.sv
// Operand-in / pair-out handshake bundle between the operand source, the
// feeder and the GCD engine.
interface gcd_operand_feeder_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic               io_op_valid;
  logic [WIDTH-1:0]   io_op_data;
  logic               io_op_ready;
  logic               io_flush;
  logic               io_out_valid;
  logic [2*WIDTH-1:0] io_out_data;
  logic               io_out_ready;
  logic [CW-1:0]      io_count;

  // slave: the feeder itself; master: the environment around it.
  modport slave (
    input  io_op_valid, io_op_data, io_flush, io_out_ready,
    output io_op_ready, io_out_valid, io_out_data, io_count
  );

  modport master (
    output io_op_valid, io_op_data, io_flush, io_out_ready,
    input  io_op_ready, io_out_valid, io_out_data, io_count
  );
endinterface

// File: rtl/gcd_operand_feeder.sv
// Pairs a serial operand stream into (A, B) words for the GCD engine and
// buffers completed pairs in a small circular FIFO.
module gcd_pair_slot #(
  parameter int PW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [PW-1:0] d,
  output logic [PW-1:0] q
);
  always_ff @(posedge clk) begin
    if (!reset)  q <= '0;
    else if (we) q <= d;
  end
endmodule

module gcd_operand_feeder #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input logic               clk,
  input logic               reset,
  gcd_operand_feeder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = 2 * WIDTH;

  typedef enum logic {EMPTY = 1'b0, HALF = 1'b1} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } pair_t;

  state_t                       state_q, state_d;
  logic [WIDTH-1:0]             a_hold;
  logic [AW-1:0]                rd_ptr, wr_ptr;
  logic [CW-1:0]                count;
  logic [DEPTH-1:0][PW-1:0]     mem;
  logic [DEPTH-1:0]             slot_we;
  pair_t                        pair_new;
  logic                         full, op_ready, op_fire, push, pop, latch_a;

  assign full     = (count == CW'(DEPTH));
  // A full FIFO only blocks the B operand; A can still be parked in a_hold.
  assign op_ready = reset & ~bus.io_flush & ~((state_q == HALF) & full);
  assign op_fire  = bus.io_op_valid & op_ready;
  assign pop      = (count != '0) & bus.io_out_ready;

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    latch_a = 1'b0;
    case (state_q)
      EMPTY: if (op_fire) begin
        latch_a = 1'b1;
        state_d = HALF;
      end
      HALF: if (op_fire) begin
        push    = 1'b1;
        state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    if (bus.io_flush) state_d = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset)       a_hold <= '0;
    else if (latch_a) a_hold <= bus.io_op_data;
  end

  // A zero B would never converge; (0, A) makes the engine return A.
  always_comb begin
    if (bus.io_op_data == '0) begin
      pair_new.a = '0;
      pair_new.b = a_hold;
    end else begin
      pair_new.a = a_hold;
      pair_new.b = bus.io_op_data;
    end
  end

  // push is already gated off by flush through op_ready.
  always_ff @(posedge clk) begin
    if (!reset || bus.io_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    assign slot_we[i] = push & (wr_ptr == AW'(i));
    gcd_pair_slot #(.PW(PW)) u_slot (
      .clk   (clk),
      .reset (reset),
      .we    (slot_we[i]),
      .d     (pair_new),
      .q     (mem[i])
    );
  end

  assign bus.io_op_ready  = op_ready;
  assign bus.io_out_valid = (count != '0);
  assign bus.io_out_data  = mem[rd_ptr];
  assign bus.io_count     = count;
endmodule

// File: tb/tb_gcd_operand_feeder.sv
// Directed plus randomized bench for gcd_operand_feeder against a queue model.
module tb_gcd_operand_feeder;
  localparam int W = 16;
  localparam int D = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gcd_operand_feeder_if #(.WIDTH(W), .DEPTH(D)) bus ();
  gcd_operand_feeder #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: queued pairs plus an optional held A operand.
  logic [2*W-1:0] q[$];
  bit             held;
  logic [W-1:0]   a_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] mkpair(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == 0) ? {{W{1'b0}}, a} : {a, b};
  endfunction

  // One clock cycle: drive at negedge, check pre-edge state, update model at posedge.
  task automatic step(input bit v, input logic [W-1:0] d, input bit ordy,
                      input bit fl, input bit rst, output bit rdy_obs, output bit fired);
    bit rdy_e, pop;
    @(negedge clk);
    reset            = rst;
    bus.io_op_valid  = v;
    bus.io_op_data   = d;
    bus.io_out_ready = ordy;
    bus.io_flush     = fl;
    #1;
    rdy_e   = rst && !fl && !(held && q.size() == D);
    rdy_obs = bus.io_op_ready;
    chk("op_ready", bus.io_op_ready, rdy_e);
    chk("out_valid", bus.io_out_valid, q.size() != 0);
    chk("count", bus.io_count, q.size());
    chk("no_overflow", bus.io_count <= D, 1);
    if (q.size() != 0) chk("out_data", bus.io_out_data, q[0]);
    fired = v && rdy_e;
    pop   = (q.size() != 0) && ordy;
    @(posedge clk);
    if (!rst || fl) begin
      q.delete();
      held = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (fired) begin
        if (!held) begin held = 1; a_m = d; end
        else begin held = 0; q.push_back(mkpair(a_m, d)); end
      end
    end
  endtask

  task automatic look(input string tag, input bit vld, input logic [2*W-1:0] data,
                      input int cnt, input bit chk_data);
    #2;
    chk({tag, "_valid"}, bus.io_out_valid, vld);
    chk({tag, "_count"}, bus.io_count, cnt);
    if (chk_data) chk({tag, "_data"}, bus.io_out_data, data);
  endtask

  task automatic drain();
    bit r, f;
    for (int i = 0; i < 12 && q.size() != 0; i++) step(0, 0, 1, 0, 1, r, f);
    #2;
    chk("drain_empty", bus.io_count, 0);
  endtask

  initial begin
    bit r, f;
    int sent, cyc;
    logic [W-1:0] ops[40];
    reset = 1'b0;
    bus.io_op_valid = 0; bus.io_op_data = 0; bus.io_out_ready = 0; bus.io_flush = 0;
    held = 0; a_m = 0;
    repeat (2) @(posedge clk);
    step(1, 16'h55, 0, 0, 0, r, f);
    chk("reset_ready_low", r, 0);
    look("reset", 0, 0, 0, 1);

    // basic pair
    step(1, 48, 1, 0, 1, r, f);
    step(1, 18, 1, 0, 1, r, f);
    look("basic", 1, 32'h00300012, 1, 1);
    step(0, 0, 1, 0, 1, r, f);

    // zero swap
    step(1, 7, 0, 0, 1, r, f);
    step(1, 0, 0, 0, 1, r, f);
    look("swap7", 1, 32'h00000007, 1, 1);
    step(0, 0, 1, 0, 1, r, f);
    step(1, 0, 0, 0, 1, r, f);
    step(1, 0, 0, 0, 1, r, f);
    look("swap00", 1, 32'h00000000, 1, 1);
    step(0, 0, 1, 0, 1, r, f);

    // fill and stall
    for (int i = 1; i <= 8; i++) step(1, W'(i), 0, 0, 1, r, f);
    look("fill", 1, 32'h00010002, 4, 1);
    step(1, 9, 0, 0, 1, r, f);
    chk("fill_op9_ready", r, 1);
    step(1, 10, 0, 0, 1, r, f);
    chk("fill_op10_blocked", r, 0);
    step(1, 10, 1, 0, 1, r, f);
    chk("fill_pop_no_passthru", r, 0);
    look("fill_pop", 1, 32'h00030004, 3, 1);
    step(1, 10, 0, 0, 1, r, f);
    chk("fill_op10_accept", r, 1);
    look("fill_tail", 1, 32'h00030004, 4, 1);
    drain();

    // wrap-around, out_ready toggling
    foreach (ops[i]) ops[i] = W'($urandom_range(1, 16'hFFFF));
    sent = 0;
    for (cyc = 0; cyc < 300 && sent < 40; cyc++) begin
      step(1, ops[sent], (cyc % 2) == 0, 0, 1, r, f);
      if (f) sent++;
    end
    chk("wrap_all_sent", sent, 40);
    drain();

    // flush mid-stream
    for (int i = 0; i < 7; i++) step(1, W'(i + 1), 0, 0, 1, r, f);
    look("pre_flush", 1, 32'h00010002, 3, 1);
    step(1, 5, 1, 1, 1, r, f);
    look("post_flush", 0, 0, 0, 0);
    step(1, 11, 0, 0, 1, r, f);
    step(1, 22, 0, 0, 1, r, f);
    look("flush_newpair", 1, 32'h000b0016, 1, 1);
    drain();

    // reset mid-operation
    for (int i = 0; i < 5; i++) step(1, W'(i + 20), 0, 0, 1, r, f);
    step(1, 3, 1, 0, 0, r, f);
    chk("midreset_ready_low", r, 0);
    look("midreset", 0, 0, 0, 1);
    step(1, 100, 0, 0, 1, r, f);
    step(1, 0, 0, 0, 1, r, f);
    look("midreset_newpair", 1, 32'h00000064, 1, 1);
    drain();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0,
           ($urandom_range(0, 7) == 0) ? W'(0) : W'($urandom),
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 29) == 0,
           $urandom_range(0, 59) != 0, r, f);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/gcd_operand_feeder.md
# gcd_operand_feeder

Upstream stage for the GCD engine. It accepts a serial stream of unsigned operands, pairs consecutive operands into (A, B) and buffers completed pairs in a small FIFO. It presents each pair to the GCD input handshake as one packed word. Pairs whose B operand is zero are swapped so the engine always terminates: the engine cannot converge on a nonzero A with a zero B.

## Interface

**Parameters**
- `WIDTH`, default 16: operand width. The packed pair is `2*WIDTH` bits wide.
- `DEPTH`, default 4: pair FIFO depth. Must be a power of two and at least 2.

**Ports**
- `clk`, input, 1: sole clock. All state changes on the rising edge.
- `reset`, input, 1: synchronous, active-low. Low at a rising edge resets all state.
- `io_op_valid`, input, 1: an operand is offered.
- `io_op_data`, input, `WIDTH`: operand value, unsigned.
- `io_op_ready`, output, 1: the feeder accepts the operand this cycle.
- `io_flush`, input, 1: synchronous discard of the held operand and all queued pairs.
- `io_out_valid`, output, 1: the FIFO head holds a pair. Connects to the GCD `io_in_valid`.
- `io_out_data`, output, `2*WIDTH`: the head pair, A in `[2*WIDTH-1:WIDTH]` and B in `[WIDTH-1:0]`. Connects to the GCD `io_in_data`.
- `io_out_ready`, input, 1: the consumer takes the head pair. Connects to the GCD `io_in_ready`.
- `io_count`, output, `log2(DEPTH)+1`: number of pairs queued.

## Operation

**Pairing FSM**
- Two states:
  - EMPTY: no operand held.
  - HALF: operand A is held in the `a_hold` register.
- Operand handshake: an operand transfers when `io_op_valid & io_op_ready`.
- EMPTY plus a transfer: latch `io_op_data` into `a_hold` and go to HALF.
- HALF plus a transfer: form the pair (`a_hold`, `io_op_data`), push it into the FIFO and go to EMPTY.

**Swap rule**
- If B == 0, push (0, A) instead of (A, 0). The engine then returns A, which is gcd(A, 0).
- If both operands are 0, push (0, 0).

**Ready rule**
- `io_op_ready` = `reset` & !`io_flush` & !(state == HALF & `io_count` == `DEPTH`).
- There is no pass-through from `io_out_ready` to `io_op_ready`. A pop in the same cycle does not free a slot for a push in that cycle.

**FIFO**
- Circular buffer with `DEPTH` entries. Read and write pointers are `log2(DEPTH)` bits wide and wrap modulo `DEPTH`.
- `io_out_valid` = (`io_count` != 0). `io_out_data` is the entry at the read pointer.
- A pop occurs when `io_out_valid & io_out_ready`.
- Push and pop in the same cycle leave `io_count` unchanged and advance both pointers.
- A push with no pop increments `io_count`. A pop with no push decrements it.
- Overflow and underflow cannot occur by construction. Verification asserts both are impossible.

**Flush**
- When `io_flush` is high at an edge: state goes to EMPTY, `io_count` to 0 and both pointers to 0.
- Flush has priority over any push or pop in the same cycle. A pop handshake that coincides with flush is still seen by the consumer, because `io_out_valid` was high during that cycle.

**Reset**
- At the edge where `reset` is low, state and storage clear exactly as for flush.
- Reset values of the outputs:
  - `io_op_ready` = 0 while `reset` is low, and 1 in the first cycle after reset is released.
  - `io_out_valid` = 0.
  - `io_out_data` = 0 (FIFO storage is cleared).
  - `io_count` = 0.
- Reset in the middle of an operation discards the held A and all queued pairs. No partial pair survives.

## Timing

- Latency: the pair formed at the edge where B is accepted is visible on `io_out_valid`/`io_out_data` in the next cycle, one cycle after B's transfer.
- Maximum throughput: one operand per cycle, which is one pair every two cycles.
- The GCD engine accepts a new pair only when idle, so the FIFO absorbs bursts while the engine iterates.
- `io_out_valid` and `io_out_data` are driven only from registers.
- `io_op_ready` is combinational from state, count, `reset` and `io_flush` only.
- Once `io_out_valid` is raised, it and `io_out_data` stay stable until a pop, a flush or a reset.

## Test plan

- **Basic pair:** operands 48, 18 on consecutive cycles with `io_out_ready`=1. Required: `io_out_valid` high on the cycle after 18 is accepted, with `io_out_data` = 0x00300012. With the GCD engine attached, its result is 6.
- **Zero swap:**
  - Operands 7, 0. Required: `io_out_data` = 0x00000007, and the attached engine returns 7.
  - Operands 0, 0. Required: 0x00000000.
- **Fill and stall:** hold `io_out_ready`=0 and offer operands 1..10. Required:
  - 8 operands accepted, `io_count` reaches 4.
  - Operand 9 is accepted and held (state HALF).
  - Operand 10 sees `io_op_ready`=0.
  - Raising `io_out_ready` for one cycle pops (1,2). `io_op_ready` stays 0 during that cycle, then goes to 1.
  - Operand 10 is accepted and pair (9,10) lands at the tail.
- **Wrap-around:** stream 20 pairs with `io_out_ready` toggling 1,0,1,0. Required: all pairs emerge in order, unmodified, and `io_count` never exceeds 4.
- **Flush mid-stream:** with 3 pairs queued and state HALF, pulse `io_flush`. Required:
  - The next cycle has `io_count`=0, `io_out_valid`=0 and state EMPTY.
  - The next two operands form the first new pair.
- **Reset mid-operation:** hold `reset` low for one edge while holding A and 2 queued pairs. Required:
  - All outputs at their reset values, and `io_op_ready`=0 while `reset` is low.
  - After release, the first operand is treated as A.
